rect_fill_engine: RTL
=====================

Name: rect_fill_engine

Overview:
- Parametrised rectangle rasteriser feeding the VGA adapter's pixel-write port (x, y, colour, plot).
- Per request it takes an arbitrary origin, width, height, colour and mode (solid fill or 1-pixel outline), then emits one pixel per cycle in raster order.
- Pixels off-screen are clipped. A hold input can stall emission.
- Sits between the board/game FSM and vga_adapter, and replaces fixed-size square drawing.

Parameters:
- X_BITS, 10, width of x coordinate
- Y_BITS, 9, width of y coordinate
- DIM_BITS, 9, width of the w/h request fields (max dimension 2^DIM_BITS-1)
- COLOUR_BITS, 3, colour width
- SCREEN_W, 320, visible width; x >= SCREEN_W is clipped
- SCREEN_H, 240, visible height; y >= SCREEN_H is clipped

Ports:
- clock  in  1  system clock (CLOCK_50)
- reset  in  1  asynchronous, active-high reset
- start  in  1  request strobe, sampled only in IDLE
- x0  in  X_BITS  rectangle origin x
- y0  in  Y_BITS  rectangle origin y
- w  in  DIM_BITS  width in pixels
- h  in  DIM_BITS  height in pixels
- colour_in  in  COLOUR_BITS  draw colour
- outline  in  1  0 = solid fill, 1 = border only
- hold  in  1  stall; counters frozen, plot forced 0
- busy  out  1  high from the cycle after accepted start through the DONE cycle
- done  out  1  single-cycle pulse on completion
- plot  out  1  write-enable to vga_adapter
- x  out  X_BITS  pixel x
- y  out  Y_BITS  pixel y
- colour  out  COLOUR_BITS  latched colour_in

Behaviour:
- States and transitions:
  - IDLE -> RUN on start when w != 0 and h != 0.
  - IDLE -> DONE on start when w == 0 or h == 0. No pixel is plotted.
  - RUN -> DONE after the last pixel (cx == w-1, cy == h-1) has been emitted with hold low.
  - DONE -> IDLE unconditionally.
- Reset (asynchronous): state IDLE; busy, done, plot = 0; x, y, colour, counters and latched request = 0.
- On accepted start, x0, y0, w, h, colour_in and outline are latched. Later input changes have no effect until the next start.
- Counters: cx runs 0..w-1. cy runs 0..h-1 and increments when cx wraps to 0. Order is raster, row-major.
- x = x0_r + cx and y = y0_r + cy. Sums are computed at X_BITS+1 / Y_BITS+1 bits so overflow is never wrapped onto the screen.
- plot = (state==RUN) && !hold && (x_sum < SCREEN_W) && (y_sum < SCREEN_H) && (!outline_r || cx==0 || cx==w_r-1 || cy==0 || cy==h_r-1).
- Clipped pixels and outline interior pixels still consume one cycle each. Pixel cycle count is always w*h, plus hold cycles.
- Latency: start sampled at edge N. The first pixel (cx=0, cy=0) is presented during cycle N+1, and busy is high in N+1. With no hold, the last pixel is presented in cycle N+w*h and done=1 in cycle N+w*h+1. busy falls in cycle N+w*h+2, and a new start is accepted at that edge.
- hold high in RUN: cx and cy do not advance, plot=0, x and y hold their value. hold in IDLE or DONE has no effect.
- start while busy is ignored, including start asserted during DONE.
- w=1 or h=1 in outline mode: every pixel is a border pixel, identical to fill.
- The x and y outputs are valid only when plot=1. In IDLE they hold their last value.

Decomposition:
- Shared package (vga_draw_pkg): state encoding (IDLE, RUN, DONE), SCREEN_W/SCREEN_H defaults, and colour constants (BLACK 3'b000, RED 3'b100, BLUE 3'b001). The existing board FSM also uses these.
- One natural sub-module: rect_scan_counter. It contains the cx/cy counters with wrap, advance enable, and last flag, parametrised by DIM_BITS.
- Clipping and outline logic stay in the top module.

Test Plan:
- Fill (x0=20, y0=20, w=4, h=3, colour=3'b100), start at cycle 0 -> 12 plots in cycles 1..12: (20,20),(21,20),(22,20),(23,20),(20,21)...(23,22); done=1 only in cycle 13; busy high cycles 1..13.
- Outline (x0=0, y0=0, w=4, h=4) -> 16 pixel cycles, 12 plots; pixels (1,1),(2,1),(1,2),(2,2) have plot=0; done in cycle 17.
- Clip (x0=318, y0=238, w=4, h=4) -> plots only at (318,238),(319,238),(318,239),(319,239); done still in cycle 17. Also (x0=1020, w=8): no wrapped plots at x=0..3.
- hold high for 5 cycles after the 2nd pixel of a 4x1 fill -> plot=0 during hold with x frozen at 21; done delayed to cycle 10; exactly 4 plots total.
- w=0 request -> no plot; done=1 in cycle 1, busy=1 in cycle 1 only. A start pulsed mid-RUN of a 40x40 fill is ignored: exactly 1600 plots.
- Async reset asserted mid-RUN between clock edges -> busy, plot and done drop immediately. After release, the next start draws from cx=cy=0 with newly latched inputs.

Source files
------------

// File: rtl/vga_draw_pkg.sv
// Shared drawing definitions for the VGA path: state encoding, screen defaults, palette.
package vga_draw_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } draw_state_e;

    localparam int unsigned SCREEN_W_DEFAULT    = 320;
    localparam int unsigned SCREEN_H_DEFAULT    = 240;
    localparam int unsigned COLOUR_BITS_DEFAULT = 3;

    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] RED   = 3'b100;
    localparam logic [2:0] BLUE  = 3'b001;

endpackage

// File: rtl/rect_fill_engine_if.sv
// Request/pixel bundle between a drawing client (master) and rect_fill_engine (slave).
interface rect_fill_engine_if #(
    parameter int unsigned X_BITS      = 10,
    parameter int unsigned Y_BITS      = 9,
    parameter int unsigned DIM_BITS    = 9,
    parameter int unsigned COLOUR_BITS = 3
);
    logic                   start;
    logic [X_BITS-1:0]      x0;
    logic [Y_BITS-1:0]      y0;
    logic [DIM_BITS-1:0]    w;
    logic [DIM_BITS-1:0]    h;
    logic [COLOUR_BITS-1:0] colour_in;
    logic                   outline;
    logic                   hold;

    logic                   busy;
    logic                   done;
    logic                   plot;
    logic [X_BITS-1:0]      x;
    logic [Y_BITS-1:0]      y;
    logic [COLOUR_BITS-1:0] colour;

    modport master (
        output start, x0, y0, w, h, colour_in, outline, hold,
        input  busy, done, plot, x, y, colour
    );

    modport slave (
        input  start, x0, y0, w, h, colour_in, outline, hold,
        output busy, done, plot, x, y, colour
    );

endinterface

// File: rtl/rect_scan_counter.sv
// Row-major cx/cy scan over a w x h rectangle; parks on the last pixel once reached.
module rect_scan_counter #(
    parameter int unsigned DIM_BITS = 9
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                clear,
    input  logic                advance,
    input  logic [DIM_BITS-1:0] w,
    input  logic [DIM_BITS-1:0] h,
    output logic [DIM_BITS-1:0] cx,
    output logic [DIM_BITS-1:0] cy,
    output logic                last
);

    localparam logic [DIM_BITS-1:0] One = DIM_BITS'(1);

    logic [DIM_BITS-1:0] cx_q, cx_d;
    logic [DIM_BITS-1:0] cy_q, cy_d;
    logic                col_last;
    logic                row_last;

    always_comb begin
        col_last = (cx_q == w - One);
        row_last = (cy_q == h - One);
        cx_d     = cx_q;
        cy_d     = cy_q;
        if (clear) begin
            cx_d = '0;
            cy_d = '0;
        end else if (advance && !(col_last && row_last)) begin
            // Holding on the final pixel keeps x/y stable after completion.
            if (col_last) begin
                cx_d = '0;
                cy_d = cy_q + One;
            end else begin
                cx_d = cx_q + One;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cx_q <= '0;
            cy_q <= '0;
        end else begin
            cx_q <= cx_d;
            cy_q <= cy_d;
        end
    end

    assign cx   = cx_q;
    assign cy   = cy_q;
    assign last = col_last && row_last;

endmodule

// File: rtl/rect_fill_engine.sv
// Rectangle rasteriser: one pixel per cycle in raster order, with clipping and outline mode.
module rect_fill_engine
    import vga_draw_pkg::*;
#(
    parameter int unsigned X_BITS      = 10,
    parameter int unsigned Y_BITS      = 9,
    parameter int unsigned DIM_BITS    = 9,
    parameter int unsigned COLOUR_BITS = COLOUR_BITS_DEFAULT,
    parameter int unsigned SCREEN_W    = SCREEN_W_DEFAULT,
    parameter int unsigned SCREEN_H    = SCREEN_H_DEFAULT
) (
    input logic               clock,
    input logic               reset,
    rect_fill_engine_if.slave bus
);

    localparam logic [X_BITS:0]   ScreenWLim = (X_BITS + 1)'(SCREEN_W);
    localparam logic [Y_BITS:0]   ScreenHLim = (Y_BITS + 1)'(SCREEN_H);
    localparam logic [DIM_BITS-1:0] DimOne   = DIM_BITS'(1);

    draw_state_e state_q, state_d;

    logic [X_BITS-1:0]      x0_q;
    logic [Y_BITS-1:0]      y0_q;
    logic [DIM_BITS-1:0]    w_q;
    logic [DIM_BITS-1:0]    h_q;
    logic [COLOUR_BITS-1:0] colour_q;
    logic                   outline_q;

    logic                   accept;
    logic                   advance;
    logic                   last;
    logic [DIM_BITS-1:0]    cx;
    logic [DIM_BITS-1:0]    cy;
    logic [X_BITS:0]        x_sum;
    logic [Y_BITS:0]        y_sum;
    logic                   on_screen;
    logic                   border;

    assign accept  = (state_q == StIdle) && bus.start;
    assign advance = (state_q == StRun) && !bus.hold;

    rect_scan_counter #(
        .DIM_BITS (DIM_BITS)
    ) u_scan (
        .clock   (clock),
        .reset   (reset),
        .clear   (accept),
        .advance (advance),
        .w       (w_q),
        .h       (h_q),
        .cx      (cx),
        .cy      (cy),
        .last    (last)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = (bus.w != '0 && bus.h != '0) ? StRun : StDone;
                end
            end
            StRun: begin
                if (advance && last) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x0_q      <= '0;
            y0_q      <= '0;
            w_q       <= '0;
            h_q       <= '0;
            colour_q  <= '0;
            outline_q <= 1'b0;
        end else if (accept) begin
            x0_q      <= bus.x0;
            y0_q      <= bus.y0;
            w_q       <= bus.w;
            h_q       <= bus.h;
            colour_q  <= bus.colour_in;
            outline_q <= bus.outline;
        end
    end

    // One extra bit so a rectangle running past the coordinate range clips instead of wrapping.
    always_comb begin
        x_sum     = {1'b0, x0_q} + (X_BITS + 1)'(cx);
        y_sum     = {1'b0, y0_q} + (Y_BITS + 1)'(cy);
        on_screen = (x_sum < ScreenWLim) && (y_sum < ScreenHLim);
        border    = (cx == '0) || (cx == w_q - DimOne) || (cy == '0) || (cy == h_q - DimOne);
    end

    always_comb begin
        bus.busy   = (state_q != StIdle);
        bus.done   = (state_q == StDone);
        bus.plot   = (state_q == StRun) && !bus.hold && on_screen && (!outline_q || border);
        bus.x      = x_sum[X_BITS-1:0];
        bus.y      = y_sum[Y_BITS-1:0];
        bus.colour = colour_q;
    end

endmodule
